// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store stage sitting behind the ALU.
// Takes ALUResult as the effective byte address and performs LW/LBU/SW/SB
// over a ready-handshake data bus, stalling the core while an access is open.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   ALUResult           effective byte address
//   WriteData           store data (rs2)
//   MemRead, MemWrite   load / store request, held by the core while stalled
//   ByteAccess          1 = byte access, 0 = word access
//   ReadData            registered, zero-extended load result
//   Done                one-cycle completion pulse
//   Stall               combinational pipeline freeze
//   MisalignErr         one-cycle error pulse, coincident with Done
//   bus_req/we/addr/wdata/be   registered bus request fields
//   bus_ready, bus_rdata       bus response
//
// state | meaning
// IDLE  | waiting for a request; accepts or rejects it on the next edge
// BUSY  | bus_req asserted, waiting for bus_ready
// DONE  | Done pulse; request inputs ignored, back to IDLE next cycle
module lsu_mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  ByteAccess,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Done,
  output logic                  Stall,
  output logic                  MisalignErr,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wdata,
  output logic [3:0]            bus_be,
  input  logic                  bus_ready,
  input  logic [31:0]           bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state, state_nxt;
  logic       req;
  logic       err;
  logic       accept;
  logic       finish;
  logic [1:0] off_q;
  logic       byte_q;

  assign req = MemRead | MemWrite;
  assign err = (!ByteAccess && (ALUResult[1:0] != 2'b00)) || (MemRead && MemWrite);

  // Stall must not leak out while reset is holding the stage.
  assign Stall = !rst && (((state == IDLE) && req) || (state == BUSY));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (err) begin
            state_nxt = DONE;
          end else begin
            state_nxt = BUSY;
            accept    = 1'b1;
          end
        end
      end
      BUSY: begin
        if (bus_ready) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_be      <= '0;
      ReadData    <= '0;
      Done        <= 1'b0;
      MisalignErr <= 1'b0;
      off_q       <= '0;
      byte_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus_req     <= (state_nxt == BUSY);
      Done        <= (state_nxt == DONE);
      // Only the rejected-request path reaches DONE straight from IDLE.
      MisalignErr <= (state == IDLE) && req && err;
      if (accept) begin
        bus_addr  <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
        bus_we    <= MemWrite;
        off_q     <= ALUResult[1:0];
        byte_q    <= ByteAccess;
        bus_be    <= ByteAccess ? (4'b0001 << ALUResult[1:0]) : 4'hF;
        bus_wdata <= ByteAccess ? {4{WriteData[7:0]}} : WriteData;
      end
      if (finish && !bus_we) begin
        ReadData <= byte_q ? {24'b0, bus_rdata[{off_q, 3'b000} +: 8]} : bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResult, WriteData;
  logic        MemRead, MemWrite, ByteAccess;
  logic [31:0] ReadData;
  logic        Done, Stall, MisalignErr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int dones  = 0;

  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  lsu_mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ALUResult(ALUResult), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ByteAccess(ByteAccess),
    .ReadData(ReadData), .Done(Done), .Stall(Stall), .MisalignErr(MisalignErr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse is matched against the oldest expected response.
  always @(negedge clk) begin
    if (!rst && Done) begin
      dones++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 expected no completion");
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("readdata", ReadData, e[31:0]);
        chk("misalign", {31'b0, MisalignErr}, {31'b0, e[32]});
      end
    end
  end

  task automatic run_op(input string name, input logic rd, input logic wr, input logic bt,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits, input logic exp_err,
                        input logic [31:0] exp_rd, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input int exp_stall);
    int  stall_cnt = 0;
    int  req_cnt   = 0;
    int  wcnt      = 0;
    bit  seen_done = 0;
    @(posedge clk);
    #1;
    MemRead    = rd;
    MemWrite   = wr;
    ByteAccess = bt;
    ALUResult  = addr;
    WriteData  = wdata;
    bus_ready  = 1'b0;
    bus_rdata  = ~rdata;
    exp_q.push_back({exp_err, exp_rd});
    pushed++;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      @(negedge clk);
      if (Done) begin
        seen_done = 1;
        chk({name, "_stall_in_done"}, {31'b0, Stall}, 32'd0);
        chk({name, "_req_in_done"}, {31'b0, bus_req}, 32'd0);
      end else begin
        if (Stall) stall_cnt++;
        if (bus_req) begin
          req_cnt++;
          chk({name, "_addr"}, bus_addr, exp_addr);
          chk({name, "_be"}, {28'b0, bus_be}, {28'b0, exp_be});
          chk({name, "_we"}, {31'b0, bus_we}, {31'b0, wr});
          if (wr) chk({name, "_wdata"}, bus_wdata, exp_wdata);
          if (wcnt == waits) begin
            bus_ready = 1'b1;
            bus_rdata = rdata;
          end else begin
            wcnt++;
          end
        end
      end
    end
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no Done expected Done within 40 cycles", name);
    end
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    bus_ready = 1'b0;
    chk({name, "_stall_cycles"}, stall_cnt, exp_stall);
    chk({name, "_req_cycles"}, req_cnt, exp_err ? 0 : waits + 1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    MemRead = 1'b1; MemWrite = 1'b0; ByteAccess = 1'b0;
    ALUResult = 32'h100; WriteData = 32'h0;
    bus_ready = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'b0, Stall}, 32'd0);
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_readdata", ReadData, 32'd0);
    chk("rst_done", {30'b0, Done, MisalignErr}, 32'd0);
    chk("rst_bus", bus_addr | bus_wdata | {28'b0, bus_be} | {31'b0, bus_we}, 32'd0);
    MemRead = 1'b0;
    rst = 1'b0;

    run_op("lw100", 1, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF,
           32'h100, 4'hF, 32'h0, 2);
    run_op("lbu103", 1, 0, 1, 32'h103, 32'h0, 32'hAABBCCDD, 0, 0, 32'h000000AA,
           32'h100, 4'b1000, 32'h0, 2);
    run_op("lbu101", 1, 0, 1, 32'h101, 32'h0, 32'hAABBCCDD, 0, 0, 32'h000000CC,
           32'h100, 4'b0010, 32'h0, 2);
    run_op("sb42", 0, 1, 1, 32'h42, 32'h12345678, 32'hFFFFFFFF, 3, 0, 32'h000000CC,
           32'h40, 4'b0100, 32'h78787878, 5);
    run_op("lw_mis", 1, 0, 0, 32'h102, 32'h0, 32'h55555555, 0, 1, 32'h000000CC,
           32'h0, 4'h0, 32'h0, 1);
    run_op("rdwr", 1, 1, 0, 32'h100, 32'h0, 32'h55555555, 0, 1, 32'h000000CC,
           32'h0, 4'h0, 32'h0, 1);

    // Reset while BUSY with the bus holding off.
    @(posedge clk);
    #1;
    MemRead = 1'b1; MemWrite = 1'b0; ByteAccess = 1'b0; ALUResult = 32'h200;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_req && n < 5);
    chk("rst_busy_entered", {31'b0, bus_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy_req", {31'b0, bus_req}, 32'd0);
    chk("rst_busy_stall", {31'b0, Stall}, 32'd0);
    chk("rst_busy_outs", ReadData | bus_addr | {28'b0, bus_be} | {30'b0, Done, MisalignErr}, 32'd0);
    MemRead = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus_ready = 1'b1;
    bus_rdata = 32'h99999999;
    repeat (3) begin
      @(negedge clk);
      chk("late_ready_req", {31'b0, bus_req}, 32'd0);
      chk("late_ready_rd", ReadData, 32'd0);
    end
    bus_ready = 1'b0;

    run_op("lw200", 1, 0, 0, 32'h200, 32'h0, 32'h0BADF00D, 0, 0, 32'h0BADF00D,
           32'h200, 4'hF, 32'h0, 2);
    run_op("sw10", 0, 1, 0, 32'h10, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 0, 32'h0BADF00D,
           32'h10, 4'hF, 32'hCAFEF00D, 2);
    run_op("lw14", 1, 0, 0, 32'h14, 32'h0, 32'h11223344, 1, 0, 32'h11223344,
           32'h14, 4'hF, 32'h0, 3);

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("done_count", dones, pushed);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store stage directly downstream of the ALU: takes ALUResult as the effective address and performs LW/LBU/SW/SB over a simple ready-handshake data-memory bus.
- Stalls the core while an access is outstanding.
- Returns zero-extended load data to writeback.
- Flags misaligned word accesses without touching the bus.

Parameters:
- DATA_WIDTH, 32, data and ALU result width; must be 32.
- ADDR_WIDTH, 32, bus address width; the low ADDR_WIDTH bits of ALUResult are used.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ALUResult  input  DATA_WIDTH  effective byte address from the ALU.
- WriteData  input  DATA_WIDTH  store data (rs2).
- MemRead  input  1  load request, held by the core while stalled.
- MemWrite  input  1  store request, held by the core while stalled.
- ByteAccess  input  1  1 = byte (LBU/SB), 0 = word (LW/SW).
- ReadData  output  DATA_WIDTH  registered load result.
- Done  output  1  one-cycle completion pulse.
- Stall  output  1  freezes PC and pipeline; combinational.
- MisalignErr  output  1  one-cycle error pulse, coincident with Done.
- bus_req  output  1  bus request, registered.
- bus_we  output  1  1 = write.
- bus_addr  output  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
- bus_wdata  output  32  write data.
- bus_be  output  4  byte enables.
- bus_ready  input  1  transfer completes this cycle when bus_req && bus_ready.
- bus_rdata  input  32  read data, valid when bus_req && bus_ready.

Behaviour:
- Reset (async, immediate): state IDLE; bus_req, bus_we, bus_addr, bus_wdata, bus_be, ReadData, Done and MisalignErr all 0. Stall forced 0 while rst is high.
- States: IDLE, BUSY, DONE.
- Request = MemRead | MemWrite.
- IDLE, no request: stay in IDLE.
- IDLE, request, error condition → DONE with MisalignErr set. Error condition is either:
  - word access with ALUResult[1:0] != 0, or
  - MemRead && MemWrite both high.
  - No bus access is made in either case.
- IDLE, valid request → BUSY. On the same edge, latch:
  - bus_addr = {ALUResult[ADDR_WIDTH-1:2], 2'b00}
  - bus_we = MemWrite
  - byte offset = ALUResult[1:0]
  - ByteAccess
  - bus_be = 4'hF for word; 4'b0001 << offset for byte (also applied on reads).
  - bus_wdata = WriteData for word; {4{WriteData[7:0]}} for byte.
- BUSY: bus_req = 1; all bus outputs held stable.
  - Stay in BUSY while !bus_ready. Wait states are unbounded.
  - On bus_ready → DONE.
  - On a read, capture ReadData = bus_rdata (word) or {24'b0, bus_rdata[8*offset +: 8]} (byte).
  - On a write, ReadData is unchanged.
- DONE: Done = 1, bus_req = 0, Stall = 0; unconditionally → IDLE next cycle.
  - MemRead/MemWrite are ignored in DONE: the same instruction is still presented.
- Stall = (state == IDLE && request) || state == BUSY. Stall is 0 in DONE.
- Latency with a zero-wait bus: accept cycle, BUSY cycle, Done cycle = 3 cycles, Stall high for 2. Each wait state adds 1 cycle.
- Error path: Stall high for 1 cycle; Done and MisalignErr high in the following cycle.
- bus_ready and bus_rdata are ignored outside BUSY.
- bus_req is deasserted for at least 1 cycle between consecutive accesses.
- Reset mid-BUSY: bus_req drops asynchronously; the outstanding transfer is abandoned and any late bus_ready is ignored.
- ReadData holds its last load value indefinitely.

Test Plan:
- LW, ALUResult=0x100, bus_ready=1 in the first BUSY cycle, bus_rdata=0xDEADBEEF → bus_addr=0x100, be=F, we=0. Stall high for 2 cycles. Third cycle: Done=1, ReadData=0xDEADBEEF.
- LBU, ALUResult=0x103, bus_rdata=0xAABBCCDD → bus_addr=0x100, be=4'b1000, ReadData=0x000000AA. LBU at 0x101 with the same data → ReadData=0x000000CC.
- SB, ALUResult=0x42, WriteData=0x12345678, bus_ready delayed 3 cycles → bus_addr=0x40, wdata=0x78787878, be=4'b0100, we=1. Stall high for 5 cycles; ReadData unchanged.
- LW at ALUResult=0x102; separately, MemRead=MemWrite=1 → no bus_req. Next cycle: Done=MisalignErr=1. Stall high exactly 1 cycle.
- rst pulsed during BUSY with bus_ready low → bus_req=0 immediately, all outputs 0. A later bus_ready=1 has no effect. A subsequent LW completes normally.
- SW at 0x10 immediately followed by LW at 0x14 → LW accepted only in the cycle after DONE. bus_req low for ≥1 cycle between the two transfers. Exactly one Done per instruction.
